// File: rtl/add_share_arb.sv
// add_share_arb: round-robin sharing of one external W-bit adder among NREQ requesters; 1-cycle latency.
// A held result with res_ready low blocks all grants; define ADD_ARB_CNT_EN for per-requester grant_cnt.
module add_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W-1:0]      add_s,
  input  logic              add_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_sum,
  output logic              res_carry,
  output logic [IDW-1:0]    res_id
`ifdef ADD_ARB_CNT_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;
  logic           found;
  logic           accept;
  logic           grant;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!found && (idx == IDW'(i)) && req_valid[i]) begin
          found  = 1'b1;
          winner = idx;
        end
      end
    end
  end

  assign accept = (state == EMPTY) || res_ready;
  assign grant  = found && accept && !rst;

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (found && (winner == IDW'(i))) begin
        add_a        = req_a[i*W +: W];
        add_b        = req_b[i*W +: W];
        req_ready[i] = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_carry <= 1'b0;
      res_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (grant) begin
            state     <= FULL;
            res_valid <= 1'b1;
          end
        end
        FULL: begin
          // A new grant while draining replaces the result in the same edge.
          if (res_ready && !grant) begin
            state     <= EMPTY;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          res_valid <= 1'b0;
        end
      endcase
      if (grant) begin
        res_sum   <= add_s;
        res_carry <= add_c;
        res_id    <= winner;
        rr_ptr    <= (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);
      end
    end
  end

`ifdef ADD_ARB_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_add_share_arb.sv
// Bench for add_share_arb: vector table, corner sequences and a queue scoreboard with an arbitration model.
module tb_add_share_arb;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W-1:0]      add_s;
  logic              add_c;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_sum;
  logic              res_carry;
  logic [IDW-1:0]    res_id;
`ifdef ADD_ARB_CNT_EN
  logic [NREQ*16-1:0] grant_cnt;
`endif

  logic [W-1:0] a_arr [NREQ];
  logic [W-1:0] b_arr [NREQ];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = a_arr[i];
      req_b[i*W +: W] = b_arr[i];
    end
  end

  // Stand-in for the external shared adder.
  assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b};

  add_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s),
    .add_c     (add_c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_id    (res_id)
`ifdef ADD_ARB_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0]   sum;
    logic           carry;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t           sbq[$];
  logic           exp_full;
  logic [IDW-1:0] exp_ptr;

  // Reference arbiter model plus scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [IDW-1:0]  w;
    logic            any;
    logic [NREQ-1:0] er;
    exp_t            e;
    logic [W:0]      s;
    if (rst) begin
      check("rst_req_ready", 32'(req_ready), 32'h0);
      sbq.delete();
      exp_full = 1'b0;
      exp_ptr  = '0;
    end else begin
      any = 1'b0;
      w   = '0;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (int'(exp_ptr) + k) % NREQ;
        if (!any && req_valid[j]) begin
          any = 1'b1;
          w   = IDW'(j);
        end
      end
      er = (any && (!exp_full || res_ready)) ? (NREQ'(1) << w) : '0;
      check("req_ready", 32'(req_ready), 32'(er));
      check("res_valid", 32'(res_valid), 32'(exp_full));
      if (res_valid && res_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: result id %0d delivered with nothing expected", res_id);
        end else begin
          e = sbq.pop_front();
          check("sb_sum", 32'(res_sum), 32'(e.sum));
          check("sb_carry", 32'(res_carry), 32'(e.carry));
          check("sb_id", 32'(res_id), 32'(e.id));
        end
      end
      if (er != '0) begin
        s       = {1'b0, a_arr[w]} + {1'b0, b_arr[w]};
        e.sum   = s[W-1:0];
        e.carry = s[W];
        e.id    = w;
        sbq.push_back(e);
        exp_ptr  = (w == IDW'(NREQ-1)) ? '0 : w + IDW'(1);
        exp_full = 1'b1;
      end else if (exp_full && res_ready) begin
        exp_full = 1'b0;
      end
    end
  end

  typedef struct {
    int           r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         carry;
  } vec_t;

  vec_t         tbl [8];
  logic [W:0]   hs;
  logic [W-1:0] held_sum;

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{0, 16'h0003, 16'h0004, 16'h0007, 1'b0};
    tbl[1] = '{0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    tbl[2] = '{1, 16'h8000, 16'h8000, 16'h0000, 1'b1};
    tbl[3] = '{2, 16'h1234, 16'h4321, 16'h5555, 1'b0};
    tbl[4] = '{3, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    tbl[5] = '{1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[6] = '{2, 16'h7FFF, 16'h0001, 16'h8000, 1'b0};
    tbl[7] = '{3, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0};

    rst       = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_res_valid", 32'(res_valid), 32'h0);
    check("reset_res_sum", 32'(res_sum), 32'h0);
    check("reset_res_carry", 32'(res_carry), 32'h0);
    check("reset_res_id", 32'(res_id), 32'h0);
`ifdef ADD_ARB_CNT_EN
    check("reset_grant_cnt", grant_cnt[31:0], 32'h0);
    check("reset_grant_cnt_hi", grant_cnt[63:32], 32'h0);
`endif

    // Single-requester vectors, including carry-out and wrap cases.
    for (int k = 0; k < 8; k++) begin
      req_valid           = NREQ'(1) << tbl[k].r;
      a_arr[tbl[k].r]     = tbl[k].a;
      b_arr[tbl[k].r]     = tbl[k].b;
      res_ready           = 1'b1;
      @(posedge clk); #1;
      req_valid = '0;
      check("vec_valid", 32'(res_valid), 32'h1);
      check("vec_sum", 32'(res_sum), 32'(tbl[k].sum));
      check("vec_carry", 32'(res_carry), 32'(tbl[k].carry));
      check("vec_id", 32'(res_id), 32'(tbl[k].r));
      @(posedge clk); #1;
      check("vec_drain", 32'(res_valid), 32'h0);
    end

    // All requesters active: strict rotation from 0, one result per cycle.
    pulse_reset();
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = W'(i * 16'h1111 + 1);
      b_arr[i] = W'(i * 16'h0100);
    end
    req_valid = '1;
    res_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      check("rot_valid", 32'(res_valid), 32'h1);
      check("rot_id", 32'(res_id), 32'(n % NREQ));
    end

    // Consumer stall: outputs frozen, nobody granted, then drain with no bubble.
    res_ready = 1'b0;
    hs        = {1'b0, a_arr[3]} + {1'b0, b_arr[3]};
    held_sum  = res_sum;
    check("stall_sum0", 32'(res_sum), 32'(hs[W-1:0]));
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      check("stall_ready", 32'(req_ready), 32'h0);
      check("stall_valid", 32'(res_valid), 32'h1);
      check("stall_id", 32'(res_id), 32'h3);
      check("stall_sum", 32'(res_sum), 32'(held_sum));
    end
    res_ready = 1'b1;
    #1;
    check("unstall_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    check("unstall_valid", 32'(res_valid), 32'h1);
    check("unstall_id", 32'(res_id), 32'h0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while holding a result; pointer must return to 0.
    a_arr[0]  = 16'h0005;
    b_arr[0]  = 16'h0006;
    req_valid = 4'b0001;
    res_ready = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", 32'(res_valid), 32'h1);
    rst       = 1'b1;
    req_valid = 4'b0100;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    check("rst_drop_valid", 32'(res_valid), 32'h0);
    rst       = 1'b0;
    req_valid = 4'b0101;
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_id0", 32'(res_id), 32'h0);
    check("post_rst_sum", 32'(res_sum), 32'h000B);
    req_valid = 4'b0100;
    @(posedge clk); #1;
    check("post_rst_id2", 32'(res_id), 32'h2);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;

`ifdef ADD_ARB_CNT_EN
    // Counter saturation on requester 1.
    pulse_reset();
    req_valid = 4'b0010;
    res_ready = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("cnt_100", 32'(grant_cnt[31:16]), 32'd100);
    repeat (69900) @(posedge clk);
    #1;
    check("cnt_sat", 32'(grant_cnt[31:16]), 32'hFFFF);
    check("cnt_0", 32'(grant_cnt[15:0]), 32'h0);
    check("cnt_23", grant_cnt[63:32], 32'h0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
